rv32i_mem_bridge: RTL and testbench

//  Sits between the multicycle core's single-cycle memory port and a slower

---
 rtl/rv32i_bus_pkg.sv | 16 +
 rtl/bus_wait_timer.sv | 32 +++
 rtl/rv32i_mem_bridge.sv | 147 ++++++++++++++
 tb/tb_rv32i_mem_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_bus_pkg.sv
// Shared types and constants for the core-to-bus memory bridge and MMIO slaves.
package rv32i_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } bridge_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts cycles spent waiting on the bus; tc flags the last permitted wait cycle.
module bus_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_r;

    // Wait counter; parks on the terminal value so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = en && (count_r == LAST);

endmodule

// File: rtl/rv32i_mem_bridge.sv
// Bridges the core's single-cycle memory port onto a req/ready word bus,
// stalling the core via core_ena and flagging misaligned or timed-out accesses.
module rv32i_mem_bridge
    import rv32i_bus_pkg::*;
#(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_req,
    input  logic [31:0]          core_addr,
    input  logic [31:0]          core_wr_data,
    input  logic                 core_wr_ena,
    output logic [31:0]          core_rd_data,
    output logic                 core_ena,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [31:0]          bus_addr,
    output logic [31:0]          bus_wdata,
    input  logic                 bus_ready,
    input  logic [31:0]          bus_rdata,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    bridge_state_t        state_r;
    bridge_state_t        state_next_s;
    logic                 bus_req_r;
    logic                 bus_we_r;
    logic [31:0]          bus_addr_r;
    logic [31:0]          bus_wdata_r;
    logic [31:0]          rd_buf_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_count_r;
    logic                 timer_tc_s;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // The timer idles at zero outside S_REQ, so every request starts from a fresh count.
    bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state_r == S_REQ),
        .clr (state_r != S_REQ),
        .tc  (timer_tc_s)
    );

    // Next-state and core stall; ready on the final timeout cycle completes normally.
    always_comb begin
        state_next_s = state_r;
        core_ena     = 1'b1;
        case (state_r)
            S_IDLE: begin
                core_ena = ~core_req;
                if (core_req) begin
                    if (core_addr[1:0] == 2'b00) begin
                        state_next_s = S_REQ;
                    end else begin
                        state_next_s = S_DONE;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_REQ: begin
                core_ena = 1'b0;
                if (bus_ready || timer_tc_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_DONE: begin
                core_ena     = 1'b1;
                state_next_s = S_IDLE;
            end
            default: begin
                core_ena     = 1'b1;
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, latched access, bus handshake outputs, read buffer and error tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            rd_buf_r    <= 32'h0000_0000;
            err_r       <= 1'b0;
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            case (state_r)
                S_IDLE: begin
                    if (core_req) begin
                        bus_addr_r  <= word_align(core_addr);
                        bus_wdata_r <= core_wr_data;
                        bus_we_r    <= core_wr_ena;
                        if (core_addr[1:0] == 2'b00) begin
                            bus_req_r <= 1'b1;
                        end else begin
                            rd_buf_r    <= 32'h0000_0000;
                            err_r       <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ready) begin
                        bus_req_r <= 1'b0;
                        if (!bus_we_r) begin
                            rd_buf_r <= bus_rdata;
                        end
                    end else if (timer_tc_s) begin
                        bus_req_r   <= 1'b0;
                        rd_buf_r    <= ERR_RDATA;
                        err_r       <= 1'b1;
                        err_count_r <= sat_inc(err_count_r);
                    end
                end
                S_DONE: begin
                    bus_req_r <= 1'b0;
                end
                default: begin
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req      = bus_req_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign bus_wdata    = bus_wdata_r;
    assign core_rd_data = rd_buf_r;
    assign err          = err_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_rv32i_mem_bridge.sv
// Directed scoreboard bench for rv32i_mem_bridge: latency, data, errors, saturation, reset.
module tb_rv32i_mem_bridge;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic [7:0]  cnt;
        int          lat;
        int          breq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wr_data = 32'h0;
    logic        core_wr_ena = 1'b0;
    logic [31:0] core_rd_data;
    logic        core_ena;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        err;
    logic [7:0]  err_count;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] model_rd = 32'h0;
    logic        model_err = 1'b0;
    logic [7:0]  model_cnt = 8'h0;

    rv32i_mem_bridge #(.TIMEOUT(TIMEOUT), .ERR_RDATA(ERR_RD), .ERR_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req     (core_req),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_wr_ena  (core_wr_ena),
        .core_rd_data (core_rd_data),
        .core_ena     (core_ena),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .err          (err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Drives one access at a negedge; ready_at is the cycle after the request
    // (1 = zero wait) at which bus_ready is raised, or -1 for never.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic we, input int ready_at, input logic [31:0] rdata);
        exp_t e;
        exp_t got;
        int   k;
        int   breq;
        bit   done;
        if (addr[1:0] != 2'b00) begin
            model_rd  = 32'h0;
            model_err = 1'b1;
            model_cnt = sat8(model_cnt);
            e.lat     = 1;
            e.breq    = 0;
        end else if (ready_at >= 1 && ready_at <= TIMEOUT) begin
            if (!we) model_rd = rdata;
            e.lat  = ready_at + 1;
            e.breq = ready_at;
        end else begin
            model_rd  = ERR_RD;
            model_err = 1'b1;
            model_cnt = sat8(model_cnt);
            e.lat     = TIMEOUT + 1;
            e.breq    = TIMEOUT;
        end
        e.rd  = model_rd;
        e.err = model_err;
        e.cnt = model_cnt;
        sb.push_back(e);

        core_req     = 1'b1;
        core_addr    = addr;
        core_wr_data = wdata;
        core_wr_ena  = we;
        #1;
        check("ena_low_on_req", {31'h0, core_ena}, 32'h0);
        k    = 0;
        breq = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            core_req = 1'b0;
            if (core_ena) begin
                done      = 1'b1;
                bus_ready = 1'b0;
            end else begin
                if (bus_req) begin
                    breq++;
                    check("bus_addr", bus_addr, {addr[31:2], 2'b00});
                    check("bus_we", {31'h0, bus_we}, {31'h0, we});
                    check("bus_wdata", bus_wdata, wdata);
                end
                bus_ready = (k == ready_at);
                bus_rdata = rdata;
            end
        end
        check("completed_in_budget", {31'h0, done}, 32'h1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("rd_data", core_rd_data, got.rd);
            check("err", {31'h0, err}, {31'h0, got.err});
            check("err_count", {24'h0, err_count}, {24'h0, got.cnt});
            check("latency", 32'(k), 32'(got.lat));
            check("bus_req_cycles", 32'(breq), 32'(got.breq));
        end
        @(negedge clk);
        check("idle_ena", {31'h0, core_ena}, 32'h1);
        check("idle_bus_req", {31'h0, bus_req}, 32'h0);
    endtask

    initial begin
        #1;
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_rd_data", core_rd_data, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_err_count", {24'h0, err_count}, 32'h0);
        check("rst_core_ena", {31'h0, core_ena}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_access(32'h0000_0100, 32'h1111_2222, 1'b0, 1, 32'h1234_5678);
        run_access(32'h0000_0204, 32'hCAFE_F00D, 1'b1, 4, 32'h5555_AAAA);
        run_access(32'h0000_0208, 32'h0, 1'b0, -1, 32'h7777_7777);
        for (int i = 0; i < 300; i++) begin
            run_access(32'h0000_0102, 32'h0, 1'b0, 1, 32'h9999_9999);
        end
        check("err_count_saturated", {24'h0, err_count}, 32'h0000_00FF);

        // Back-to-back loads, each answered on the last cycle before timeout.
        run_access(32'h0000_0500, 32'h0, 1'b0, TIMEOUT, 32'hAAAA_0001);
        run_access(32'h0000_0504, 32'h0, 1'b0, TIMEOUT, 32'hBBBB_0002);

        // Reset asserted between edges while the bus request is outstanding.
        core_req    = 1'b1;
        core_addr   = 32'h0000_0300;
        core_wr_ena = 1'b0;
        @(negedge clk);
        core_req = 1'b0;
        @(negedge clk);
        check("pre_reset_bus_req", {31'h0, bus_req}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("async_rst_core_ena", {31'h0, core_ena}, 32'h1);
        check("async_rst_err", {31'h0, err}, 32'h0);
        check("async_rst_err_count", {24'h0, err_count}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_rd  = 32'h0;
        model_err = 1'b0;
        model_cnt = 8'h0;
        @(negedge clk);
        run_access(32'h0000_0400, 32'h0, 1'b0, 2, 32'hA5A5_5A5A);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
